// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over WIDTH steps, then a sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SIG_MD_START,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             SIG_HI_W,
  input  logic             SIG_LO_W,
  input  logic [WIDTH-1:0] data_write,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;
  logic [WIDTH-1:0] r_b;
  logic            r_op_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_busy;
  logic            r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic            w_load;
  logic            w_step;
  logic            w_fix;
  logic            w_last;

  // Operand conditioning: signed ops work on magnitudes, signs re-applied in FIX
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_signed = ~md_op[0];
  assign w_a_neg  = w_signed & src_a[WIDTH-1];
  assign w_b_neg  = w_signed & src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-src_a) : src_a;
  assign w_b_mag  = w_b_neg ? (-src_b) : src_b;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Accumulator holds {partial, multiplier} for mult and {remainder, quotient} for div
  logic [WIDTH:0]  w_mul_sum;
  logic [WIDTH:0]  w_div_shift;
  logic [WIDTH:0]  w_div_diff;
  logic            w_div_ok;
  logic [AW-1:0]   w_acc_step;

  assign w_mul_sum   = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_div_shift = r_acc[AW-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  always_comb begin
    w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_op_div) begin
      if (w_div_ok) begin
        w_acc_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_step = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [AW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_prod = r_neg_q ? (-r_acc) : r_acc;
  assign w_quo  = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (-r_acc[AW-1:WIDTH]) : r_acc[AW-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (SIG_MD_START) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, status and HI/LO; MTHI/MTLO only land when idle and no start competes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_cnt    <= '0;
        r_op_div <= md_op[1];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_busy   <= 1'b1;
        if (md_op[1]) begin
          r_acc <= {{WIDTH{1'b0}}, w_a_mag};
          r_b   <= w_b_mag;
        end else begin
          r_acc <= {{WIDTH{1'b0}}, w_b_mag};
          r_b   <= w_a_mag;
        end
      end
      if (w_step) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fix) begin
        r_busy <= 1'b0;
        if (r_op_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod[AW-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if ((r_state == S_IDLE) && !SIG_MD_START) begin
        if (SIG_HI_W) begin
          r_hi <= data_write;
        end
        if (SIG_LO_W) begin
          r_lo <= data_write;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
